column_slice_renderer: RTL and testbench

- Frame-level initiator for find_slice_height: steps column_count 0..SCREEN_W-1, pulses begin_calc, waits for end_calc, then latches slice_size.
- For each column it draws one vertical slice into the VGA adapter: a ceiling span, a centred wall span of height slice_size, and a floor span.
- Sits between the top-level game FSM (start_frame/frame_done) and the VGA adapter plot interface (x, y, colour, plot).

---
 rtl/raycast_pkg.sv | 28 ++
 rtl/slice_row_shader.sv | 21 ++
 rtl/column_slice_renderer.sv | 193 +++++++++++++++++++
 tb/tb_column_slice_renderer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/raycast_pkg.sv
// Shared raycaster constants: screen geometry, slice colours and the
// column renderer state encoding.
package raycast_pkg;

  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int CALC_TIMEOUT = 255;

  localparam logic [2:0] CEIL_COLOUR  = 3'b001;
  localparam logic [2:0] WALL_COLOUR  = 3'b111;
  localparam logic [2:0] FLOOR_COLOUR = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_CALC = 3'd2,
    S_LATCH     = 3'd3,
    S_DRAW      = 3'd4,
    S_NEXT_COL  = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  // Projected heights above the screen are drawn as a full-height wall.
  function automatic logic [6:0] clamp_height(input logic [6:0] size);
    return (size > 7'(SCREEN_H)) ? 7'(SCREEN_H) : size;
  endfunction

endpackage

// File: rtl/slice_row_shader.sv
// Combinational row shader: maps a row to ceiling, wall or floor colour
// given the wall span [top, bottom).
module slice_row_shader
  import raycast_pkg::*;
(
  input  logic [6:0] i_y,
  input  logic [6:0] i_top,
  input  logic [6:0] i_bottom,
  output logic [2:0] o_colour
);

  always_comb begin
    o_colour = FLOOR_COLOUR;
    if (i_y < i_top) begin
      o_colour = CEIL_COLOUR;
    end else if (i_y < i_bottom) begin
      o_colour = WALL_COLOUR;
    end
  end

endmodule

// File: rtl/column_slice_renderer.sv
// Frame renderer: requests one slice height per column from the height
// calculator and plots a ceiling/wall/floor column into the VGA adapter.
// Optional build macro CALC_TIMEOUT_EN adds a WAIT_CALC watchdog and the
// sticky timeout_seen output.
module column_slice_renderer
  import raycast_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       start_frame,
  output logic       begin_calc,
  output logic [7:0] column_count,
  input  logic       end_calc,
  input  logic [6:0] slice_size,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done,
`ifdef CALC_TIMEOUT_EN
  output logic       timeout_seen,
`endif
  output logic [2:0] dbg_state
);

  // Handshake with the height calculator: begin_calc is a single-cycle
  // request carrying column_count; end_calc is only looked at in WAIT_CALC,
  // and slice_size is taken one cycle later, in LATCH.
  state_t     r_state;
  logic [7:0] r_col;
  logic [6:0] r_top;
  logic [6:0] r_bottom;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot;
  logic       r_begin_calc;
  logic       r_busy;
  logic       r_frame_done;

`ifdef CALC_TIMEOUT_EN
  logic [7:0] r_wd;
  logic       r_force_zero;
  logic       r_timeout_seen;
`endif

  logic [6:0] w_h;
  logic [6:0] w_top;
  logic [6:0] w_bottom;
  logic [6:0] w_shade_y;
  logic [6:0] w_shade_top;
  logic [6:0] w_shade_bottom;
  logic [2:0] w_colour;

`ifdef CALC_TIMEOUT_EN
  assign w_h = r_force_zero ? 7'd0 : clamp_height(slice_size);
`else
  assign w_h = clamp_height(slice_size);
`endif

  assign w_top    = (7'(SCREEN_H) - w_h) >> 1;
  assign w_bottom = w_top + w_h;

  // The shader looks one row ahead so colour is registered alongside y;
  // in LATCH the span registers are not loaded yet, so use the fresh values.
  assign w_shade_y      = (r_state == S_DRAW)  ? (r_y + 7'd1) : 7'd0;
  assign w_shade_top    = (r_state == S_LATCH) ? w_top        : r_top;
  assign w_shade_bottom = (r_state == S_LATCH) ? w_bottom     : r_bottom;

  slice_row_shader u_shader (
    .i_y      (w_shade_y),
    .i_top    (w_shade_top),
    .i_bottom (w_shade_bottom),
    .o_colour (w_colour)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_col          <= 8'd0;
      r_top          <= 7'd0;
      r_bottom       <= 7'd0;
      r_x            <= 8'd0;
      r_y            <= 7'd0;
      r_colour       <= 3'd0;
      r_plot         <= 1'b0;
      r_begin_calc   <= 1'b0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
`ifdef CALC_TIMEOUT_EN
      r_wd           <= 8'd0;
      r_force_zero   <= 1'b0;
      r_timeout_seen <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_frame) begin
            r_state      <= S_REQ;
            r_col        <= 8'd0;
            r_begin_calc <= 1'b1;
            r_busy       <= 1'b1;
`ifdef CALC_TIMEOUT_EN
            r_timeout_seen <= 1'b0;
`endif
          end
        end

        S_REQ: begin
          r_begin_calc <= 1'b0;
          r_state      <= S_WAIT_CALC;
`ifdef CALC_TIMEOUT_EN
          r_wd         <= 8'd0;
          r_force_zero <= 1'b0;
`endif
        end

        S_WAIT_CALC: begin
          if (end_calc) begin
            r_state <= S_LATCH;
          end
`ifdef CALC_TIMEOUT_EN
          else if (r_wd == 8'(CALC_TIMEOUT - 1)) begin
            r_state        <= S_LATCH;
            r_force_zero   <= 1'b1;
            r_timeout_seen <= 1'b1;
          end else begin
            r_wd <= r_wd + 8'd1;
          end
`endif
        end

        S_LATCH: begin
          r_top    <= w_top;
          r_bottom <= w_bottom;
          r_x      <= r_col;
          r_y      <= 7'd0;
          r_colour <= w_colour;
          r_plot   <= 1'b1;
          r_state  <= S_DRAW;
        end

        S_DRAW: begin
          if (r_y == 7'(SCREEN_H - 1)) begin
            r_plot   <= 1'b0;
            r_y      <= 7'd0;
            r_colour <= 3'd0;
            r_state  <= S_NEXT_COL;
          end else begin
            r_y      <= r_y + 7'd1;
            r_colour <= w_colour;
          end
        end

        S_NEXT_COL: begin
          if (r_col == 8'(SCREEN_W - 1)) begin
            r_frame_done <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_col        <= r_col + 8'd1;
            r_begin_calc <= 1'b1;
            r_state      <= S_REQ;
          end
        end

        S_DONE: begin
          r_frame_done <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign begin_calc   = r_begin_calc;
  assign column_count = r_col;
  assign x            = r_x;
  assign y            = r_y;
  assign colour       = r_colour;
  assign plot         = r_plot;
  assign busy         = r_busy;
  assign frame_done   = r_frame_done;
  assign dbg_state    = r_state;
`ifdef CALC_TIMEOUT_EN
  assign timeout_seen = r_timeout_seen;
`endif

endmodule

// File: tb/tb_column_slice_renderer.sv
// Directed/randomised bench for column_slice_renderer with a row-colour
// reference model and an expected-pixel queue.
module tb_column_slice_renderer;
  import raycast_pkg::*;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start_frame = 1'b0;
  logic       end_calc = 1'b0;
  logic [6:0] slice_size = 7'd0;
  logic       begin_calc;
  logic [7:0] column_count;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       frame_done;
  logic [2:0] dbg_state;
`ifdef CALC_TIMEOUT_EN
  logic       timeout_seen;
`endif

  int total = 0;
  int bad = 0;
  int n_begin = 0;
  int n_plot = 0;
  int n_done = 0;
  logic [17:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  column_slice_renderer dut (
    .clock        (clock),
    .resetn       (resetn),
    .start_frame  (start_frame),
    .begin_calc   (begin_calc),
    .column_count (column_count),
    .end_calc     (end_calc),
    .slice_size   (slice_size),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .plot         (plot),
    .busy         (busy),
    .frame_done   (frame_done),
`ifdef CALC_TIMEOUT_EN
    .timeout_seen (timeout_seen),
`endif
    .dbg_state    (dbg_state)
  );

  always @(negedge clock) begin
    if (begin_calc === 1'b1) n_begin++;
    if (plot === 1'b1) n_plot++;
    if (frame_done === 1'b1) n_done++;
  end

  // ---------------- reference model ----------------
  function automatic logic [2:0] ref_colour(input int size, input int row);
    int h;
    int top;
    h = (size > 120) ? 120 : size;
    top = (120 - h) / 2;
    if (row < top) return 3'b001;
    if (row < top + h) return 3'b111;
    return 3'b010;
  endfunction

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_begin_calc"}, 32'(begin_calc), 32'(0));
    chk({tag, "_column_count"}, 32'(column_count), 32'(0));
    chk({tag, "_xyc"}, 32'({x, y, colour}), 32'(0));
    chk({tag, "_plot"}, 32'(plot), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_frame_done"}, 32'(frame_done), 32'(0));
    chk({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
`ifdef CALC_TIMEOUT_EN
    chk({tag, "_timeout_seen"}, 32'(timeout_seen), 32'(0));
`endif
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    start_frame = 1'b0;
    end_calc = 1'b0;
    repeat (2) step();
    check_idle_zero(tag);
    resetn = 1'b1;
    step();
  endtask

  // One column: answer the request after lat cycles, then check all 120 pixels.
  task automatic do_column(input int col, input int size, input int lat,
                           input bit early, input int abort_y, input bit poke);
    int n;
    logic [17:0] e;
    n = 0;
    while (begin_calc !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("begin_calc_seen", 32'(begin_calc), 32'(1));
    if (begin_calc !== 1'b1) return;
    chk("column_count", 32'(column_count), 32'(col));
    chk("busy_req", 32'(busy), 32'(1));
    start_frame = 1'b0;
    end_calc = early;
    slice_size = 7'($urandom_range(0, 127));
    step();
    chk("begin_calc_one_shot", 32'(begin_calc), 32'(0));
    end_calc = 1'b0;
    for (int i = 0; i < lat; i++) begin
      step();
      chk("no_plot_wait", 32'(plot), 32'(0));
    end
    end_calc = 1'b1;
    step();
    end_calc = 1'b0;
    slice_size = 7'(size);
    chk("plot_latch", 32'(plot), 32'(0));
    for (int r = 0; r < 120; r++) exp_q.push_back({8'(col), 7'(r), ref_colour(size, r)});
    step();
    for (int r = 0; r < 120; r++) begin
      e = exp_q.pop_front();
      chk("plot_draw", 32'(plot), 32'(1));
      chk("pixel", 32'({x, y, colour}), 32'(e));
      if (r == abort_y) begin
        resetn = 1'b0;
        exp_q.delete();
        return;
      end
      if (poke && r == 60) start_frame = 1'b1;
      step();
    end
    chk("plot_next_col", 32'(plot), 32'(0));
    chk("frame_done_mid", 32'(frame_done), 32'(0));
  endtask

  task automatic run_frame(input bit rand_size);
    int sz;
    start_frame = 1'b1;
    for (int c = 0; c < 160; c++) begin
      sz = rand_size ? int'($urandom_range(0, 127)) : 40;
      do_column(c, sz, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                999, (c % 37 == 5));
    end
    step();
    chk("frame_done_pulse", 32'(frame_done), 32'(1));
    chk("busy_in_done", 32'(busy), 32'(1));
    step();
    chk("frame_done_clear", 32'(frame_done), 32'(0));
    chk("busy_after_done", 32'(busy), 32'(0));
    chk("state_after_done", 32'(dbg_state), 32'(S_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int b0;
    int p0;
    int d0;
    int n;
    int sizes[4];
    sizes[0] = 60;
    sizes[1] = 61;
    sizes[2] = 0;
    sizes[3] = 127;

    do_reset("reset");

    for (int k = 0; k < 4; k++) begin
      b0 = n_begin;
      p0 = n_plot;
      start_frame = 1'b1;
      do_column(0, sizes[k], (k == 0) ? 10 : int'($urandom_range(0, 6)), 1'(k == 1), 999, 1'b0);
      do_reset("abort_col0");
      chk("col0_begin_count", 32'(n_begin - b0), 32'(1));
      chk("col0_plot_count", 32'(n_plot - p0), 32'(120));
    end

    b0 = n_begin;
    p0 = n_plot;
    d0 = n_done;
    run_frame(1'b0);
    step();
    chk("frame_begin_count", 32'(n_begin - b0), 32'(160));
    chk("frame_plot_count", 32'(n_plot - p0), 32'(19200));
    chk("frame_done_count", 32'(n_done - d0), 32'(1));
    chk("idle_after_frame", 32'(dbg_state), 32'(S_IDLE));

    run_frame(1'b1);
    step();

    d0 = n_done;
    start_frame = 1'b1;
    for (int c = 0; c < 5; c++) do_column(c, int'($urandom_range(0, 127)), 2, 1'b0, 999, 1'b0);
    do_column(5, 70, 3, 1'b0, 50, 1'b0);
    step();
    check_idle_zero("reset_draw");
    resetn = 1'b1;
    repeat (5) step();
    chk("no_frame_done_after_abort", 32'(n_done - d0), 32'(0));
    start_frame = 1'b1;
    do_column(0, 90, 1, 1'b0, 999, 1'b0);
    do_reset("restart");

`ifdef CALC_TIMEOUT_EN
    start_frame = 1'b1;
    n = 0;
    while (begin_calc !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    start_frame = 1'b0;
    chk("to_begin_calc", 32'(begin_calc), 32'(1));
    chk("to_seen_clear", 32'(timeout_seen), 32'(0));
    slice_size = 7'd100;
    n = 0;
    step();
    while (plot !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    chk("to_latency", 32'(n), 32'(256));
    for (int r = 0; r < 120; r++) begin
      chk("to_pixel", 32'({x, y, colour}), 32'({8'd0, 7'(r), ref_colour(0, r)}));
      step();
    end
    chk("to_seen_set", 32'(timeout_seen), 32'(1));
    do_column(1, 50, 2, 1'b0, 999, 1'b0);
    do_reset("to_reset");
`else
    n = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
